// File: rtl/mask_pkg.sv
// mask_pkg
// Shared constants and helpers for the first-order masking front end.
//   LFSR_W         width of the Fibonacci LFSR
//   LFSR_TAPS      tap mask for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0)
//   ZERO_SEED_SUB  value loaded instead of an all-zero seed
//   state_t        encoder control states
//   share0_idx / share1_idx  bit positions of the two shares of operand bit i
//   lfsr_feedback  feedback bit of one single-bit Fibonacci step
package mask_pkg;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    WARMUP   = 2'd1,
    READY    = 2'd2
  } state_t;

  // share0 carries the masked value, share1 the raw mask
  function automatic int share0_idx(input int i);
    return 2 * i;
  endfunction

  function automatic int share1_idx(input int i);
    return 2 * i + 1;
  endfunction

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/mask_encoder_lfsr_step.sv
// lfsr_step
// Purely combinational K-bit parallel advance of the 32-bit Fibonacci LFSR.
// The register shifts toward the MSB, so after K single steps the K LSBs of
// the new state are exactly the K freshly generated bits.
//   state_in   current LFSR state
//   state_out  state after K steps
//   rnd        K fresh random bits (LSBs of state_out)
module lfsr_step
  import mask_pkg::*;
#(
  parameter int K = 3
) (
  input  logic [LFSR_W-1:0] state_in,
  output logic [LFSR_W-1:0] state_out,
  output logic [K-1:0]      rnd
);

  logic [LFSR_W-1:0] s;

  // Unrolled chain of single-bit steps; each iteration feeds the next
  always_comb begin
    s = state_in;
    for (int i = 0; i < K; i++) begin
      s = {s[LFSR_W-2:0], lfsr_feedback(s)};
    end
  end

  assign state_out = s;
  assign rnd       = s[K-1:0];

endmodule

// File: rtl/mask_encoder.sv
// mask_encoder
// First-order Boolean masking front end for DOM AND gadgets. Splits each
// accepted (x, y) pair into two shares with fresh LFSR randomness and adds one
// independent refresh bit per gadget. Owns the PRNG, its seeding and warm-up.
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   seed_load/seed one-cycle pulse that loads the LFSR and restarts warm-up
//   in_valid/in_ready/x/y         unmasked operand handshake
//   out_valid/out_ready           shared operand handshake
//   a_sh, b_sh     shares of x and y (bit 2i = share0, bit 2i+1 = share1)
//   refresh        one fresh random bit per gadget
//   busy           high while unseeded or warming up
module mask_encoder
  import mask_pkg::*;
#(
  parameter int DATA_W     = 1,
  parameter int WARMUP_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_load,
  input  logic [31:0]         seed,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   x,
  input  logic [DATA_W-1:0]   y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] a_sh,
  output logic [2*DATA_W-1:0] b_sh,
  output logic [DATA_W-1:0]   refresh,
  output logic                busy
);

  localparam int K = 3 * DATA_W;
  localparam int CNT_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_CYC - 1);

  state_t            state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [K-1:0]      rnd;
  logic [CNT_W-1:0]  warm_cnt_q;
  logic [LFSR_W-1:0] seed_val;
  logic              accept;

  logic [DATA_W-1:0]   m_a;
  logic [DATA_W-1:0]   m_b;
  logic [DATA_W-1:0]   m_r;
  logic [2*DATA_W-1:0] a_nxt;
  logic [2*DATA_W-1:0] b_nxt;

  lfsr_step #(.K(K)) u_lfsr_step (
    .state_in  (lfsr_q),
    .state_out (lfsr_nxt),
    .rnd       (rnd)
  );

  assign in_ready = (state_q == READY) && (!out_valid || out_ready);
  assign busy     = (state_q != READY);

  // A seed load always wins over a simultaneous transfer
  assign accept   = in_valid && in_ready && !seed_load;

  // An all-zero LFSR would lock up, so a zero seed is substituted
  assign seed_val = (seed == '0) ? ZERO_SEED_SUB : seed;

  // Share construction: the only point where x meets its mask is one XOR,
  // and share1 is the raw mask bit itself
  always_comb begin
    m_a   = rnd[DATA_W-1:0];
    m_b   = rnd[2*DATA_W-1:DATA_W];
    m_r   = rnd[3*DATA_W-1:2*DATA_W];
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      a_nxt[share0_idx(i)] = x[i] ^ m_a[i];
      a_nxt[share1_idx(i)] = m_a[i];
      b_nxt[share0_idx(i)] = y[i] ^ m_b[i];
      b_nxt[share1_idx(i)] = m_b[i];
    end
  end

  // Control FSM, warm-up counter, LFSR and output register. The LFSR free-runs
  // during warm-up and afterwards advances only when a pair is accepted, so
  // every accepted pair consumes exactly one fresh step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= UNSEEDED;
      lfsr_q     <= ZERO_SEED_SUB;
      warm_cnt_q <= '0;
      out_valid  <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      refresh    <= '0;
    end else if (seed_load) begin
      state_q    <= WARMUP;
      lfsr_q     <= seed_val;
      warm_cnt_q <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state_q)
        UNSEEDED: begin
          state_q <= UNSEEDED;
        end
        WARMUP: begin
          lfsr_q <= lfsr_nxt;
          if (warm_cnt_q == CNT_LAST) begin
            state_q <= READY;
          end else begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
          end
        end
        READY: begin
          if (accept) begin
            lfsr_q    <= lfsr_nxt;
            a_sh      <= a_nxt;
            b_sh      <= b_nxt;
            refresh   <= m_r;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_q <= UNSEEDED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_encoder.sv
// tb_mask_encoder
// Self-checking bench for mask_encoder with a cycle-level behavioural model
// (plain LFSR arithmetic, warm-up countdown and a valid flag) and a DOM AND
// gadget model used to recombine the shares.
module tb_mask_encoder;
  import mask_pkg::*;

  localparam int DATA_W     = 1;
  localparam int WARMUP_CYC = 16;
  localparam int K          = 3 * DATA_W;

  localparam int M_UNSEEDED = 0;
  localparam int M_WARM     = 1;
  localparam int M_READY    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                seed_load;
  logic [31:0]         seed;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   x;
  logic [DATA_W-1:0]   y;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] a_sh;
  logic [2*DATA_W-1:0] b_sh;
  logic [DATA_W-1:0]   refresh;
  logic                busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  int                m_st;
  int                m_warm;
  logic [31:0]       m_lfsr;
  logic              m_ov;
  logic [DATA_W-1:0] m_x, m_y, m_ma, m_mb, m_mr;
  int                m_accepts;
  int                seen_xfers;

  mask_encoder #(.DATA_W(DATA_W), .WARMUP_CYC(WARMUP_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_sh      (a_sh),
    .b_sh      (b_sh),
    .refresh   (refresh),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // K single-bit steps of x^32+x^22+x^2+x+1, shifting toward the MSB
  function automatic logic [31:0] model_advance(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < K; k++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    return t;
  endfunction

  function automatic logic [2*DATA_W-1:0] exp_pack(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W-1:0] m);
    logic [2*DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) begin
      p[2*i]   = v[i] ^ m[i];
      p[2*i+1] = m[i];
    end
    return p;
  endfunction

  function automatic logic model_ready();
    return (m_st == M_READY) && (!m_ov || out_ready);
  endfunction

  task automatic model_reset();
    m_st = M_UNSEEDED; m_warm = 0; m_lfsr = 32'h1; m_ov = 1'b0;
    m_x = '0; m_y = '0; m_ma = '0; m_mb = '0; m_mr = '0;
  endtask

  // One clock edge; the model follows the inputs that the edge samples
  task automatic tick();
    logic [31:0] t;
    logic        xfer;
    xfer = out_valid && out_ready && !seed_load && !rst;
    @(posedge clk);
    if (xfer) seen_xfers++;
    if (rst) begin
      model_reset();
    end else if (seed_load) begin
      m_lfsr = (seed == 0) ? 32'h1 : seed;
      m_warm = WARMUP_CYC; m_ov = 1'b0; m_st = M_WARM;
    end else if (m_st == M_WARM) begin
      m_lfsr = model_advance(m_lfsr);
      m_warm--;
      if (m_warm == 0) m_st = M_READY;
    end else if (m_st == M_READY) begin
      if (in_valid && (!m_ov || out_ready)) begin
        t = model_advance(m_lfsr);
        m_ma = t[DATA_W-1:0];
        m_mb = t[2*DATA_W-1:DATA_W];
        m_mr = t[3*DATA_W-1:2*DATA_W];
        m_x = x; m_y = y; m_ov = 1'b1; m_lfsr = t;
        m_accepts++;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; seed_load = 1'b0; seed = '0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    checks++; if ({a_sh, b_sh, refresh} !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", {a_sh, b_sh, refresh}); end
    checks++; if (dut.lfsr_q !== 32'h1) begin errors++; $display("[TB] FAIL reset_lfsr: got %h expected 00000001", dut.lfsr_q); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL unseeded_idle: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
  endtask

  task automatic test_seed_warmup(input logic [31:0] sd);
    int busy_cycles;
    seed_load = 1'b1; seed = sd; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    busy_cycles = busy ? 1 : 0;
    tick();
    seed_load = 1'b0;
    for (int c = 0; c < WARMUP_CYC + 8 && busy; c++) begin
      busy_cycles++;
      tick();
    end
    checks++; if (busy_cycles != WARMUP_CYC + 1) begin errors++; $display("[TB] FAIL warmup_busy_cycles: got %0d expected %0d", busy_cycles, WARMUP_CYC + 1); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL warmup_ready: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    checks++; if (dut.lfsr_q !== m_lfsr) begin errors++; $display("[TB] FAIL warmup_lfsr: got %h expected %h", dut.lfsr_q, m_lfsr); end
  endtask

  task automatic test_stream(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; x = DATA_W'($urandom); y = DATA_W'($urandom);
      #1;
      checks++; if (in_ready !== model_ready()) begin errors++; $display("[TB] FAIL stream_in_ready[%0d]: got %b expected %b", i, in_ready, model_ready()); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_out_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (a_sh !== exp_pack(m_x, m_ma) || b_sh !== exp_pack(m_y, m_mb)) begin errors++; $display("[TB] FAIL stream_shares[%0d]: got a=%b b=%b expected a=%b b=%b", i, a_sh, b_sh, exp_pack(m_x, m_ma), exp_pack(m_y, m_mb)); end
      checks++; if (refresh !== m_mr) begin errors++; $display("[TB] FAIL stream_refresh[%0d]: got %b expected %b", i, refresh, m_mr); end
      checks++; if ((a_sh[0] ^ a_sh[1]) !== m_x[0] || (b_sh[0] ^ b_sh[1]) !== m_y[0]) begin errors++; $display("[TB] FAIL stream_recombine[%0d]: got x=%b y=%b expected x=%b y=%b", i, a_sh[0] ^ a_sh[1], b_sh[0] ^ b_sh[1], m_x, m_y); end
    end
    checks++; if (dut.lfsr_q !== m_lfsr) begin errors++; $display("[TB] FAIL stream_lfsr: got %h expected %h", dut.lfsr_q, m_lfsr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] lfsr_before;
    m_accepts = m_ov ? 1 : 0;
    seen_xfers = 0;
    lfsr_before = m_lfsr;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; x = DATA_W'($urandom); y = DATA_W'($urandom);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || a_sh !== exp_pack(m_x, m_ma) || b_sh !== exp_pack(m_y, m_mb) || refresh !== m_mr) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got v=%b a=%b b=%b r=%b expected v=1 a=%b b=%b r=%b", i, out_valid, a_sh, b_sh, refresh, exp_pack(m_x, m_ma), exp_pack(m_y, m_mb), m_mr); end
      checks++; if (dut.lfsr_q !== lfsr_before) begin errors++; $display("[TB] FAIL stall_lfsr[%0d]: got %h expected %h", i, dut.lfsr_q, lfsr_before); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; x = DATA_W'($urandom); y = DATA_W'($urandom);
      tick();
      checks++; if (out_valid !== 1'b1 || a_sh !== exp_pack(m_x, m_ma) || b_sh !== exp_pack(m_y, m_mb)) begin errors++; $display("[TB] FAIL release_data[%0d]: got v=%b a=%b b=%b expected v=1 a=%b b=%b", i, out_valid, a_sh, b_sh, exp_pack(m_x, m_ma), exp_pack(m_y, m_mb)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_out_valid: got %b expected 0", out_valid); end
    checks++; if (seen_xfers != m_accepts) begin errors++; $display("[TB] FAIL transfer_count: got %0d expected %0d", seen_xfers, m_accepts); end
  endtask

  task automatic test_seed_collision();
    logic [31:0] sd;
    int          busy_cycles;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = DATA_W'($urandom); y = DATA_W'($urandom);
      tick();
    end
    sd = $urandom | 32'h0000_0100;
    seed_load = 1'b1; seed = sd; in_valid = 1'b1; out_ready = 1'b0;
    x = ~m_x; y = ~m_y;
    tick();
    seed_load = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL collide_out_valid: got %b expected 0", out_valid); end
    checks++; if (a_sh !== exp_pack(m_x, m_ma) || b_sh !== exp_pack(m_y, m_mb)) begin errors++; $display("[TB] FAIL collide_not_taken: got a=%b b=%b expected a=%b b=%b", a_sh, b_sh, exp_pack(m_x, m_ma), exp_pack(m_y, m_mb)); end
    checks++; if (dut.lfsr_q !== sd) begin errors++; $display("[TB] FAIL collide_lfsr: got %h expected %h", dut.lfsr_q, sd); end
    busy_cycles = 0;
    for (int c = 0; c < WARMUP_CYC + 8 && busy; c++) begin
      busy_cycles++;
      tick();
    end
    checks++; if (busy_cycles != WARMUP_CYC) begin errors++; $display("[TB] FAIL collide_busy_cycles: got %0d expected %0d", busy_cycles, WARMUP_CYC); end
    checks++; if (dut.lfsr_q !== m_lfsr) begin errors++; $display("[TB] FAIL collide_warm_lfsr: got %h expected %h", dut.lfsr_q, m_lfsr); end
  endtask

  task automatic test_zero_seed();
    int run;
    int max_run;
    bit nonzero_ok;
    seed_load = 1'b1; seed = '0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    checks++; if (dut.lfsr_q !== 32'h1) begin errors++; $display("[TB] FAIL zero_seed_load: got %h expected 00000001", dut.lfsr_q); end
    for (int c = 0; c < WARMUP_CYC + 8 && busy; c++) tick();
    checks++; if (busy !== 1'b0 || dut.lfsr_q !== m_lfsr) begin errors++; $display("[TB] FAIL zero_seed_warmup: got busy=%b lfsr=%h expected 0/%h", busy, dut.lfsr_q, m_lfsr); end
    run = 0; max_run = 0; nonzero_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; x = DATA_W'($urandom); y = DATA_W'($urandom);
      tick();
      if ({refresh, a_sh[1], b_sh[1]} == '0) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (dut.lfsr_q == '0) nonzero_ok = 1'b0;
      checks++; if (refresh !== m_mr || a_sh !== exp_pack(m_x, m_ma)) begin errors++; $display("[TB] FAIL zero_seed_stream[%0d]: got r=%b a=%b expected r=%b a=%b", i, refresh, a_sh, m_mr, exp_pack(m_x, m_ma)); end
    end
    checks++; if (max_run >= 32) begin errors++; $display("[TB] FAIL zero_run: got %0d expected below 32", max_run); end
    checks++; if (!nonzero_ok) begin errors++; $display("[TB] FAIL lfsr_nonzero: got 0 expected nonzero"); end
  endtask

  task automatic test_async_reset_dom();
    logic [DATA_W-1:0] q0, q1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = DATA_W'($urandom); y = DATA_W'($urandom);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL async_rst_outputs: got v=%b rdy=%b busy=%b expected 0/0/1", out_valid, in_ready, busy); end
    checks++; if (dut.state_q !== UNSEEDED || dut.lfsr_q !== 32'h1) begin errors++; $display("[TB] FAIL async_rst_state: got st=%0d lfsr=%h expected %0d/00000001", dut.state_q, dut.lfsr_q, UNSEEDED); end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL after_rst_unseeded: got busy=%b rdy=%b expected 1/0", busy, in_ready); end
    test_seed_warmup($urandom);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; x = DATA_W'($urandom); y = DATA_W'($urandom);
      tick();
      // DOM AND: q0 = a0b0 ^ (a0b1 ^ z), q1 = a1b1 ^ (a1b0 ^ z)
      for (int g = 0; g < DATA_W; g++) begin
        q0[g] = (a_sh[2*g] & b_sh[2*g]) ^ ((a_sh[2*g] & b_sh[2*g+1]) ^ refresh[g]);
        q1[g] = (a_sh[2*g+1] & b_sh[2*g+1]) ^ ((a_sh[2*g+1] & b_sh[2*g]) ^ refresh[g]);
      end
      checks++; if (out_valid !== 1'b1 || (q0 ^ q1) !== (m_x & m_y)) begin errors++; $display("[TB] FAIL dom_product[%0d]: got v=%b p=%b expected v=1 p=%b", i, out_valid, q0 ^ q1, m_x & m_y); end
    end
    checks++; if (dut.lfsr_q !== m_lfsr) begin errors++; $display("[TB] FAIL dom_lfsr: got %h expected %h", dut.lfsr_q, m_lfsr); end
  endtask

  initial begin
    m_accepts = 0;
    seen_xfers = 0;
    test_reset();
    test_seed_warmup(32'hACE1_2025);
    test_stream(64);
    test_backpressure();
    test_seed_collision();
    test_zero_seed();
    test_async_reset_dom();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
